// File: rtl/lsu_pkg.sv
// Shared types for the load/store unit: access-size encodings, FSM states
// and the byte-lane mask helper used by the lane aligner.
package lsu_pkg;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10,
    SZ_RSVD = 2'b11
  } size_e;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    RD_ISSUE = 3'd1,
    RD_WAIT  = 3'd2,
    WR_ISSUE = 3'd3,
    RESP     = 3'd4
  } state_e;

  // Byte enables (little-endian) touched by an access of the given size.
  function automatic logic [3:0] lane_mask(input size_e size, input logic [1:0] addr_lo);
    case (size)
      SZ_BYTE: lane_mask = 4'b0001 << addr_lo;
      SZ_HALF: lane_mask = addr_lo[1] ? 4'b1100 : 4'b0011;
      default: lane_mask = 4'b1111;
    endcase
  endfunction

endpackage

// File: rtl/lsu_if.sv
// Bus interfaces of the load/store unit: the execute-side request/response
// channel and the word-only data-memory channel.
interface lsu_req_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [1:0]        req_size;
  logic              req_signed;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic              resp_valid;
  logic [DATA_W-1:0] resp_rdata;
  logic              resp_err;

  modport master (
    output req_valid, req_we, req_size, req_signed, req_addr, req_wdata,
    input  req_ready, resp_valid, resp_rdata, resp_err
  );

  modport slave (
    input  req_valid, req_we, req_size, req_signed, req_addr, req_wdata,
    output req_ready, resp_valid, resp_rdata, resp_err
  );
endinterface

interface lsu_mem_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              mem_read;
  logic              mem_write;
  logic [ADDR_W-1:0] mem_address;
  logic [DATA_W-1:0] mem_write_data;
  logic [DATA_W-1:0] mem_read_data;
  logic              mem_ready;

  modport master (
    output mem_read, mem_write, mem_address, mem_write_data,
    input  mem_read_data, mem_ready
  );

  modport slave (
    input  mem_read, mem_write, mem_address, mem_write_data,
    output mem_read_data, mem_ready
  );
endinterface

// File: rtl/lsu_lane_align.sv
// Combinational lane handling for the load/store unit: extracts and
// sign/zero-extends a load from a memory word, and merges sub-word store
// data into a previously read word (read-modify-write).
module lsu_lane_align
  import lsu_pkg::*;
(
  input  size_e       size,
  input  logic        sign_ext,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] rdata,
  input  logic [31:0] wdata,
  output logic [31:0] load_data,
  output logic [31:0] merged
);

  logic [31:0]        shifted;
  logic signed [7:0]  lo_byte;
  logic signed [15:0] lo_half;
  logic [31:0]        rep;
  logic [3:0]         mask;

  // Load path: shift the addressed lane(s) down to bit 0, then extend.
  always_comb begin
    shifted   = rdata >> {addr_lo, 3'b000};
    lo_byte   = shifted[7:0];
    lo_half   = shifted[15:0];
    load_data = rdata;
    case (size)
      SZ_BYTE: load_data = sign_ext ? {{24{lo_byte[7]}}, lo_byte} : {24'd0, lo_byte};
      SZ_HALF: load_data = sign_ext ? {{16{lo_half[15]}}, lo_half} : {16'd0, lo_half};
      default: load_data = rdata;
    endcase
  end

  // Store path: replicate store data across lanes, keep only addressed bytes.
  always_comb begin
    mask = lane_mask(size, addr_lo);
    case (size)
      SZ_BYTE: rep = {4{wdata[7:0]}};
      SZ_HALF: rep = {2{wdata[15:0]}};
      default: rep = wdata;
    endcase
    for (int i = 0; i < 4; i++) begin
      merged[i*8 +: 8] = mask[i] ? rep[i*8 +: 8] : rdata[i*8 +: 8];
    end
  end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: bridges one execute-stage request at a time onto a
// word-only data memory. Sub-word stores are done as read-modify-write.
// Optional feature: define LSU_MISALIGN_TRAP_EN to flag misaligned half/word
// accesses with resp_err instead of silently aligning them.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic      clk,
  input  logic      reset_n,
  lsu_req_if.slave  req,
  lsu_mem_if.master mem
);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_n;
  size_e             size_q, size_n;
  logic              signed_q;
  logic              we_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] rdata_q;
  logic              err_n;
  logic              accept;
  logic [31:0]       load_ext;
  logic [31:0]       merged;
`ifdef LSU_MISALIGN_TRAP_EN
  logic              err_q;
`endif

  assign accept = req.req_valid && (state_q == IDLE);

  // Decode the incoming request: normalise size, then trap or align.
  always_comb begin
    size_n = (size_e'(req.req_size) == SZ_RSVD) ? SZ_WORD : size_e'(req.req_size);
    addr_n = req.req_addr;
    err_n  = 1'b0;
`ifdef LSU_MISALIGN_TRAP_EN
    err_n  = ((size_n == SZ_HALF) && req.req_addr[0]) ||
             ((size_n == SZ_WORD) && (req.req_addr[1:0] != 2'b00));
`else
    if (size_n == SZ_HALF) addr_n[0]   = 1'b0;
    if (size_n == SZ_WORD) addr_n[1:0] = 2'b00;
`endif
  end

  lsu_lane_align u_align (
    .size      (size_q),
    .sign_ext  (signed_q),
    .addr_lo   (addr_q[1:0]),
    .rdata     (mem.mem_read_data),
    .wdata     (wdata_q),
    .load_data (load_ext),
    .merged    (merged)
  );

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // Request latch on accept; read data captured in RD_WAIT into either the
  // load result or the merged RMW write word.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      addr_q   <= '0;
      size_q   <= SZ_BYTE;
      signed_q <= 1'b0;
      we_q     <= 1'b0;
      wdata_q  <= '0;
      rdata_q  <= '0;
`ifdef LSU_MISALIGN_TRAP_EN
      err_q    <= 1'b0;
`endif
    end else begin
      if (accept) begin
        addr_q   <= addr_n;
        size_q   <= size_n;
        signed_q <= req.req_signed;
        we_q     <= req.req_we;
        wdata_q  <= req.req_wdata;
        rdata_q  <= '0;
`ifdef LSU_MISALIGN_TRAP_EN
        err_q    <= err_n;
`endif
      end else if (state_q == RD_WAIT) begin
        if (we_q) wdata_q <= merged;
        else      rdata_q <= load_ext;
      end
    end
  end

  // Next-state and output decode.
  always_comb begin
    state_d            = state_q;
    req.req_ready      = 1'b0;
    req.resp_valid     = 1'b0;
    req.resp_rdata     = '0;
    req.resp_err       = 1'b0;
    mem.mem_read       = 1'b0;
    mem.mem_write      = 1'b0;
    mem.mem_address    = {addr_q[ADDR_W-1:2], 2'b00};
    mem.mem_write_data = wdata_q;
    case (state_q)
      IDLE: begin
        req.req_ready = 1'b1;
        if (req.req_valid) begin
          if (err_n)                                 state_d = RESP;
          else if (req.req_we && size_n == SZ_WORD)  state_d = WR_ISSUE;
          else                                       state_d = RD_ISSUE;
        end
      end
      RD_ISSUE: begin
        mem.mem_read = mem.mem_ready;
        if (mem.mem_ready) state_d = RD_WAIT;
      end
      RD_WAIT: state_d = we_q ? WR_ISSUE : RESP;
      WR_ISSUE: begin
        mem.mem_write = mem.mem_ready;
        if (mem.mem_ready) state_d = RESP;
      end
      RESP: begin
        req.resp_valid = 1'b1;
        req.resp_rdata = rdata_q;
`ifdef LSU_MISALIGN_TRAP_EN
        req.resp_err   = err_q;
`endif
        state_d        = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

endmodule
